wordle_guess_ctrl: RTL and testbench
====================================

# wordle_guess_ctrl

Game-sequencing controller that sits between the on-screen keyboard cursor block and the display/scoring logic. It gathers letters selected on the keyboard into a 5-letter guess and supports delete and submit. On submit it scores the guess against a latched target word with a sequential two-pass Wordle scorer (greens, then yellows, with correct duplicate-letter handling). It then advances through up to six guess rows and ends in a win or lose state acknowledged by the user.

## Interface
- No parameters; word length 5, letter code width 5, row count 6 are fixed.
- Clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; returns block to QI
- Start  in  1  level; in QI, latches target and begins a game
- Ack  in  1  level; in QDONE, returns to QI
- sel  in  1  single-cycle pulse; append `letter` to the guess
- del  in  1  single-cycle pulse; remove the last letter
- enter  in  1  single-cycle pulse; submit the guess
- letter  in  5  keyboard code under cursor; 0–25 = A–Z, 26–27 = punctuation
- target  in  25  target word; letter k at [5k+4:5k], k=0 leftmost
- guess  out  25  current guess buffer, same packing as target
- guess_len  out  3  letters entered, 0–5
- row  out  3  number of guesses scored, 0–6
- fb  out  10  last feedback; letter k at [2k+1:2k]; 00 none, 01 gray, 10 yellow, 11 green
- fb_valid  out  1  one-cycle pulse when fb updates
- win, lose  out  1  game result flags
- q_I, q_Entry, q_Check, q_Done  out  1  one-hot state

## Operation
- Reset values: state QI; guess=0, guess_len=0, row=0, fb=0, fb_valid=0, win=0, lose=0. The internal target register also clears to 0.
- QI:
  - Start=1: latch target; clear guess, guess_len, row, fb, win, lose; go to QENTRY.
  - Otherwise hold.
- QENTRY, one action per cycle, priority enter > del > sel:
  - enter with guess_len==5: go to QCHECK. With guess_len<5 it is ignored.
  - del with guess_len>0: clear slot guess_len-1 to 0 and decrement guess_len. With guess_len==0 it is ignored.
  - sel with guess_len<5 and letter≤25: write letter to slot guess_len and increment. Otherwise it is ignored.
- QCHECK: 5-bit step counter cnt, 0–29. Internal registers: per-slot mark[k] and target-used[j], both cleared on entry.
  - Green pass, cnt 0–4, i=cnt: if guess[i]==target[i], mark[i]=green and used[i]=1.
  - Yellow pass, cnt 5–29, i=(cnt-5)/5, j=(cnt-5)%5: if mark[i] is unset, used[j]=0, and guess[i]==target[j], then mark[i]=yellow and used[j]=1.
  - Any slot still unmarked after the yellow pass is gray.
  - On the cnt==29 edge:
    - Load fb from the final marks and pulse fb_valid.
    - Increment row.
    - All green: win=1, go to QDONE.
    - Else if the new row==6: lose=1, go to QDONE.
    - Else: clear guess and guess_len, go to QENTRY.
  - sel, del, enter and Start are ignored in QCHECK.
- QDONE:
  - guess, fb, row, win and lose hold.
  - Ack=1: go to QI. win, lose and fb hold until the next Start.
- Unreachable state encodings go to QI on the next edge.
- reset has priority over all inputs in every state, including mid-QCHECK; any partial scoring is discarded.

## Timing
- sel and del take effect on the sampling edge: guess and guess_len update the next cycle.
- If enter is sampled at edge E0, q_Check is high for the 30 cycles following E0. State, fb, row, win and lose update at edge E30. fb_valid is high only for the cycle after E30.
- Scoring latency from enter to fb_valid is 30 cycles and independent of data.
- Every output is registered; none depends combinationally on an input.

## Test plan
- Win path: reset; Start with target CRANE (2,17,0,13,4); sel ×5 spelling CRANE; enter. Expect q_Check for 30 cycles, then fb=10'h3FF, fb_valid one cycle, win=1, row=1, q_Done=1. Then Ack → q_I, with win still 1.
- Duplicates: target APPLE, guess PAPER. Expect fb=10'h1BA (Y,Y,G,Y,gray), win=0, row=1, state QENTRY, guess_len=0.
- Editing boundaries:
  - A 6th sel is ignored (guess_len stays 5).
  - del at guess_len 0 is ignored.
  - enter at guess_len 4 is ignored (stays QENTRY).
  - sel with letter=26 is ignored.
  - del+sel in the same cycle: only the delete happens.
- Lose path: six distinct wrong guesses. Expect row counting 1..6, lose=1 after the 6th scoring, q_Done=1, win=0.
- Reset mid-check: assert reset at cnt≈12 of QCHECK. Next cycle shows q_I=1 with all outputs at reset values. fb_valid never pulses.
- Replay: from QDONE, Ack then Start with a new target. Expect win/lose/fb/row cleared and q_Entry=1. Inputs pulsed during QCHECK cause no change to guess.

Source files
------------

// File: rtl/wordle_guess_ctrl.sv
// Wordle guess entry and sequential two-pass scorer.
// Collects five letters, scores them against a latched target, tracks six rows.
module wordle_guess_ctrl (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Ack,
  input  logic        sel,
  input  logic        del,
  input  logic        enter,
  input  logic [4:0]  letter,
  input  logic [24:0] target,
  output logic [24:0] guess,
  output logic [2:0]  guess_len,
  output logic [2:0]  row,
  output logic [9:0]  fb,
  output logic        fb_valid,
  output logic        win,
  output logic        lose,
  output logic        q_I,
  output logic        q_Entry,
  output logic        q_Check,
  output logic        q_Done
);

  typedef enum logic [3:0] {
    QI     = 4'b0001,
    QENTRY = 4'b0010,
    QCHECK = 4'b0100,
    QDONE  = 4'b1000
  } state_t;

  state_t      state, state_nx;
  logic [24:0] tgt, gbuf;
  logic [2:0]  len, row_q;
  logic [9:0]  fb_q, mark, mark_nx, fb_fin;
  logic [4:0]  used, used_nx, cnt, idx;
  logic [2:0]  yi, yj;
  logic        fbv, win_q, lose_q;
  logic        last, all_green;
  logic        do_enter, do_del, do_sel;

  function automatic logic [4:0] slot(
    input logic [24:0] w,
    input logic [2:0]  k
  );
    return w[5*k +: 5];
  endfunction

  assign do_enter = enter && (len == 3'd5);
  assign do_del   = !enter && del && (len != 3'd0);
  assign do_sel   = !enter && !del && sel &&
                    (len < 3'd5) && (letter <= 5'd25);
  assign last     = (cnt == 5'd29);

  // Yellow pass walks guess slot yi against target slot yj
  always_comb begin
    idx = cnt - 5'd5;
    yi  = 3'd0;
    yj  = idx[2:0];
    if (idx >= 5'd20) begin
      yi = 3'd4;
      yj = 3'(idx - 5'd20);
    end else if (idx >= 5'd15) begin
      yi = 3'd3;
      yj = 3'(idx - 5'd15);
    end else if (idx >= 5'd10) begin
      yi = 3'd2;
      yj = 3'(idx - 5'd10);
    end else if (idx >= 5'd5) begin
      yi = 3'd1;
      yj = 3'(idx - 5'd5);
    end
  end

  always_comb begin
    mark_nx = mark;
    used_nx = used;
    if (cnt < 5'd5) begin
      if (slot(gbuf, cnt[2:0]) == slot(tgt, cnt[2:0])) begin
        mark_nx[2*cnt[2:0] +: 2] = 2'b11;
        used_nx[cnt[2:0]]        = 1'b1;
      end
    end else if ((mark[2*yi +: 2] == 2'b00) && !used[yj] &&
                 (slot(gbuf, yi) == slot(tgt, yj))) begin
      mark_nx[2*yi +: 2] = 2'b10;
      used_nx[yj]        = 1'b1;
    end
  end

  always_comb begin
    fb_fin = '0;
    for (int k = 0; k < 5; k++) begin
      fb_fin[2*k +: 2] = (mark_nx[2*k +: 2] == 2'b00) ?
                         2'b01 : mark_nx[2*k +: 2];
    end
  end

  assign all_green = (fb_fin == 10'h3FF);

  always_ff @(posedge Clk) begin
    if (reset) state <= QI;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = QI;
    case (state)
      QI:     state_nx = Start ? QENTRY : QI;
      QENTRY: state_nx = do_enter ? QCHECK : QENTRY;
      QCHECK: begin
        if (!last)                 state_nx = QCHECK;
        else if (all_green)        state_nx = QDONE;
        else if (row_q == 3'd5)    state_nx = QDONE;
        else                       state_nx = QENTRY;
      end
      QDONE:  state_nx = Ack ? QI : QDONE;
      default: state_nx = QI;
    endcase
  end

  always_comb begin
    q_I     = (state == QI);
    q_Entry = (state == QENTRY);
    q_Check = (state == QCHECK);
    q_Done  = (state == QDONE);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      tgt    <= '0;
      gbuf   <= '0;
      len    <= '0;
      row_q  <= '0;
      fb_q   <= '0;
      fbv    <= 1'b0;
      win_q  <= 1'b0;
      lose_q <= 1'b0;
      cnt    <= '0;
      mark   <= '0;
      used   <= '0;
    end else begin
      fbv <= 1'b0;
      case (state)
        QI: begin
          if (Start) begin
            tgt    <= target;
            gbuf   <= '0;
            len    <= '0;
            row_q  <= '0;
            fb_q   <= '0;
            win_q  <= 1'b0;
            lose_q <= 1'b0;
          end
        end
        QENTRY: begin
          if (do_enter) begin
            cnt  <= '0;
            mark <= '0;
            used <= '0;
          end else if (do_del) begin
            gbuf[5*(int'(len)-1) +: 5] <= 5'd0;
            len <= len - 3'd1;
          end else if (do_sel) begin
            gbuf[5*len +: 5] <= letter;
            len <= len + 3'd1;
          end
        end
        QCHECK: begin
          mark <= mark_nx;
          used <= used_nx;
          cnt  <= cnt + 5'd1;
          if (last) begin
            fb_q  <= fb_fin;
            fbv   <= 1'b1;
            row_q <= row_q + 3'd1;
            if (all_green) begin
              win_q <= 1'b1;
            end else if (row_q == 3'd5) begin
              lose_q <= 1'b1;
            end else begin
              gbuf <= '0;
              len  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign guess     = gbuf;
  assign guess_len = len;
  assign row       = row_q;
  assign fb        = fb_q;
  assign fb_valid  = fbv;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// Directed bench for wordle_guess_ctrl.
// Win, duplicate scoring, edit limits, lose, mid-check reset, replay.
module tb_wordle_guess_ctrl;

  logic        Clk = 0;
  logic        reset, Start, Ack, sel, del, enter;
  logic [4:0]  letter;
  logic [24:0] target, guess;
  logic [2:0]  guess_len, row;
  logic [9:0]  fb;
  logic        fb_valid, win, lose;
  logic        q_I, q_Entry, q_Check, q_Done;

  int n_checks = 0;
  int n_fail   = 0;

  wordle_guess_ctrl dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack),
    .sel(sel), .del(del), .enter(enter), .letter(letter),
    .target(target), .guess(guess), .guess_len(guess_len),
    .row(row), .fb(fb), .fb_valid(fb_valid), .win(win),
    .lose(lose), .q_I(q_I), .q_Entry(q_Entry),
    .q_Check(q_Check), .q_Done(q_Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [24:0] w5(input int a, b, c, d, e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic sel_l(input logic [4:0] l);
    sel = 1; letter = l;
    tick;
    sel = 0;
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int k = 0; k < 5; k++) sel_l(w[5*k +: 5]);
  endtask

  task automatic begin_game(input logic [24:0] t);
    target = t; Start = 1;
    tick;
    Start = 0;
  endtask

  // Submit, optionally poke inputs during scoring, check latency
  task automatic score(input logic [24:0] g, input bit junk);
    int cyc;
    enter = 1;
    tick;
    enter = 0;
    cyc = 0;
    while (q_Check && cyc < 40) begin
      cyc++;
      sel = junk; del = junk; Start = junk; letter = 5'd7;
      if (cyc == 20) check("guess_held", guess, g);
      tick;
    end
    sel = 0; del = 0; Start = 0;
    check("check_cycles", cyc, 30);
    check("fb_valid_hi", fb_valid, 1);
  endtask

  localparam logic [24:0] CRANE = 25'(2 | (17 << 5) | (0 << 10) | (13 << 15) | (4 << 20));
  localparam logic [24:0] APPLE = 25'(0 | (15 << 5) | (15 << 10) | (11 << 15) | (4 << 20));
  localparam logic [24:0] PAPER = 25'(15 | (0 << 5) | (15 << 10) | (4 << 15) | (17 << 20));

  initial begin
    bit seen;
    logic [24:0] wrong;
    reset = 1; Start = 0; Ack = 0; sel = 0; del = 0; enter = 0;
    letter = 0; target = 0;
    tick; tick;
    reset = 0;
    check("rst_qI", q_I, 1);
    check("rst_guess", guess, 0);
    check("rst_len", guess_len, 0);
    check("rst_row_fb", {row, fb, fb_valid, win, lose}, 0);

    // Win path
    begin_game(CRANE);
    check("start_entry", q_Entry, 1);
    type_word(w5(2, 17, 0, 13, 4));
    check("crane_guess", guess, CRANE);
    check("crane_len", guess_len, 5);
    sel_l(5'd3);
    check("sixth_sel_len", guess_len, 5);
    check("sixth_sel_guess", guess, CRANE);
    score(CRANE, 0);
    check("win_fb", fb, 10'h3FF);
    check("win_flag", win, 1);
    check("win_row", row, 1);
    check("win_done", q_Done, 1);
    tick;
    check("fb_valid_lo", fb_valid, 0);
    Ack = 1; tick; Ack = 0;
    check("ack_qI", q_I, 1);
    check("ack_win_hold", win, 1);
    check("ack_fb_hold", fb, 10'h3FF);

    // Replay with APPLE; editing limits
    begin_game(APPLE);
    check("replay_clear", {row, fb, win, lose}, 0);
    check("replay_entry", q_Entry, 1);
    del = 1; tick; del = 0;
    check("del_empty", guess_len, 0);
    sel_l(5'd26);
    check("sel_punct", guess_len, 0);
    sel_l(5'd15); sel_l(5'd0); sel_l(5'd15); sel_l(5'd4);
    check("four_len", guess_len, 4);
    enter = 1; tick; enter = 0;
    check("enter_short", {q_Entry, guess_len}, {1'b1, 3'd4});
    sel_l(5'd17);
    del = 1; sel = 1; letter = 5'd3;
    tick;
    del = 0; sel = 0;
    check("del_sel_len", guess_len, 4);
    check("del_sel_guess", guess, w5(15, 0, 15, 4, 0));
    sel_l(5'd17);
    check("paper_guess", guess, PAPER);
    score(PAPER, 1);
    check("dup_fb", fb, 10'h1BA);
    check("dup_state", {win, row, q_Entry, guess_len}, {1'b0, 3'd1, 1'b1, 3'd0});
    check("dup_guess_clr", guess, 0);

    // Lose path: five more all-gray guesses
    for (int r = 2; r <= 6; r++) begin
      wrong = w5(r == 2 ? 1 : r == 3 ? 2 : r == 4 ? 3 : r == 5 ? 5 : 6,
                 1, 2, 3, 6);
      type_word(wrong);
      score(wrong, 0);
      check("lose_row", row, r);
      check("lose_fb", fb, 10'h155);
      if (r < 6) check("lose_mid", {lose, q_Entry}, 2'b01);
    end
    check("lose_flag", lose, 1);
    check("lose_done", {q_Done, win}, 2'b10);
    Ack = 1; tick; Ack = 0;
    check("lose_ack", {q_I, lose}, 2'b11);

    // Reset during scoring
    begin_game(CRANE);
    check("replay2", {row, fb, lose, q_Entry}, {3'd0, 10'd0, 1'b0, 1'b1});
    type_word(w5(1, 1, 1, 1, 1));
    score(w5(1, 1, 1, 1, 1), 0);
    check("pre_rst_fb", {row, fb}, {3'd1, 10'h155});
    type_word(CRANE);
    enter = 1; tick; enter = 0;
    seen = 0;
    repeat (12) begin
      seen |= fb_valid;
      tick;
    end
    reset = 1; tick; reset = 0;
    check("midrst_qI", q_I, 1);
    check("midrst_guess", {guess, guess_len}, 0);
    check("midrst_out", {row, fb, fb_valid, win, lose}, 0);
    repeat (35) begin
      seen |= fb_valid;
      tick;
    end
    check("midrst_nofbv", seen, 0);
    check("midrst_stay", q_I, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
